// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply / restoring divide for the EX stage.
// Stalls the pipeline while running, then reports a 2*WIDTH result on HI/LO
// for one completion cycle; results hold until the next completion.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            b_zero_q, b_zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_out_q, hi_out_d;
    logic [WIDTH-1:0] lo_out_q, lo_out_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    // Datapath signals shared by the next-state logic
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_acc, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Operand magnitudes, one iteration step and the sign-corrected final result
    always_comb begin
        a_neg     = i_op[0] & i_a[WIDTH-1];
        b_neg     = i_op[0] & i_b[WIDTH-1];
        a_mag     = a_neg ? -i_a : i_a;
        b_mag     = b_neg ? -i_b : i_b;

        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};

        div_trial = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];

        if (op_q[1]) begin
            step_acc = div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo  = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        prod      = {step_acc, step_lo};
        prod_fix  = neg_res_q ? -prod : prod;
        quot_fix  = b_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -step_lo : step_lo);
        rem_fix   = neg_rem_q ? -step_acc : step_acc;
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequencer and its datapath registers
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        hi_out_d  = hi_out_q;
        lo_out_d  = lo_out_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start && !i_flush) begin
                    state_d   = RUN;
                    count_d   = COUNT_LOAD;
                    op_d      = i_op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (i_b == {WIDTH{1'b0}});
                    acc_d     = {WIDTH{1'b0}};
                    lo_d      = i_op[1] ? a_mag : b_mag;
                    opnd_d    = i_op[1] ? b_mag : a_mag;
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = step_acc;
                    lo_d    = step_lo;
                    count_d = count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        hi_out_d = op_q[1] ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                        lo_out_d = op_q[1] ? quot_fix : prod_fix[WIDTH-1:0];
                        dbz_d    = op_q[1] & b_zero_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            hi_out_q  <= '0;
            lo_out_q  <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            hi_out_q  <= hi_out_d;
            lo_out_q  <= lo_out_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // The stall is raised in the accept cycle itself so ID/EX holds from that cycle
    assign o_busy        = (state_q == RUN) ||
                           ((state_q == IDLE) && i_start && !i_flush && !rst);
    assign o_done        = done_q;
    assign o_hi          = hi_out_q;
    assign o_lo          = lo_out_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: self-checking bench for ex_muldiv_unit with directed
// vectors, randomized operations against an arithmetic reference model,
// flush, mid-run reset and back-to-back issue.
module tb_ex_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_div_by_zero;

    int checks;
    int errors;

    logic [31:0] r_hi, r_lo;
    logic        r_dbz;
    int          r_lat;
    int          r_busy_bad;

    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_flush       (i_flush),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference result {div_by_zero, hi, lo} computed with plain integer arithmetic
    function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] hi, lo;
        logic        dbz;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'd0: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = 64'(sa * sb);    hi = p[63:32]; lo = p[31:0]; end
            2'd2: begin
                if (b == 0) begin dbz = 1'b1; lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin dbz = 1'b1; lo = '1; hi = a; end
                else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
        endcase
        return {dbz, hi, lo};
    endfunction

    // Issue one op at the next negedge (cycle 0), scramble inputs while running,
    // and record latency, results and any cycle whose busy level was wrong
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        r_busy_bad = 0;
        r_lat      = -1;
        for (int cyc = 0; cyc < LAT + 10; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                i_start = 1'b1; i_flush = 1'b0; i_op = op; i_a = a; i_b = b;
            end else begin
                i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
            end
            #1;
            if (o_done) begin
                r_lat = cyc; r_hi = o_hi; r_lo = o_lo; r_dbz = o_div_by_zero;
                if (o_busy) r_busy_bad++;
                i_start = 1'b0;
                break;
            end
            if (!o_busy) r_busy_bad++;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_hi, o_lo, o_done, o_div_by_zero, o_busy} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got hi=%h lo=%h done=%b dbz=%b busy=%b, expected all zero",
                     o_hi, o_lo, o_done, o_div_by_zero, o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_mulu_max();
        logic [31:0] hi_keep, lo_keep;
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (r_lat !== LAT) begin
            errors++; $display("[TB] FAIL mulu_latency: got %0d expected %0d", r_lat, LAT);
        end
        checks++;
        if (r_busy_bad !== 0) begin
            errors++; $display("[TB] FAIL mulu_busy: got %0d bad cycles expected 0", r_busy_bad);
        end
        checks++;
        if ({r_hi, r_lo} !== 64'hFFFFFFFE_00000001) begin
            errors++; $display("[TB] FAIL mulu_result: got %h_%h expected fffffffe_00000001", r_hi, r_lo);
        end
        hi_keep = r_hi;
        lo_keep = r_lo;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_done, o_busy, o_hi, o_lo} !== {2'b00, hi_keep, lo_keep}) begin
            errors++;
            $display("[TB] FAIL mulu_hold: got done=%b busy=%b %h_%h expected done=0 busy=0 %h_%h",
                     o_done, o_busy, o_hi, o_lo, hi_keep, lo_keep);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [7] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd3};
        logic [31:0] t_a   [7] = '{32'd100, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                                   32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] t_b   [7] = '{32'd0, 32'd7, 32'h80000000, 32'd2, 32'd0, 32'd7, 32'hFFFFFFFF};
        logic [64:0] t_exp [7] = '{{1'b1, 32'h00000064, 32'hFFFFFFFF},
                                   {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB},
                                   {1'b0, 32'h40000000, 32'h00000000},
                                   {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD},
                                   {1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF},
                                   {1'b0, 32'h00000002, 32'h0000000E},
                                   {1'b0, 32'h00000000, 32'h80000000}};
        for (int i = 0; i < 7; i++) begin
            run_op(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (r_lat !== LAT || r_busy_bad !== 0) begin
                errors++;
                $display("[TB] FAIL directed_timing[%0d]: got latency %0d bad-busy %0d expected %0d 0",
                         i, r_lat, r_busy_bad, LAT);
            end
            checks++;
            if ({r_dbz, r_hi, r_lo} !== t_exp[i]) begin
                errors++;
                $display("[TB] FAIL directed_result[%0d]: got dbz=%b %h_%h expected dbz=%b %h_%h",
                         i, r_dbz, r_hi, r_lo, t_exp[i][64], t_exp[i][63:32], t_exp[i][31:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [64:0] exp_v;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'h80000000;
                3: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            exp_v = ref_model(op, a, b);
            run_op(op, a, b);
            checks++;
            if (r_lat !== LAT || {r_dbz, r_hi, r_lo} !== exp_v) begin
                errors++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d dbz=%b %h_%h expected lat=%0d dbz=%b %h_%h",
                         n, op, a, b, r_lat, r_dbz, r_hi, r_lo, LAT, exp_v[64], exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    task automatic test_flush();
        int dones;
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (r_lo !== 32'h1) begin
            errors++; $display("[TB] FAIL flush_setup_lo: got %h expected 00000001", r_lo);
        end
        for (int cyc = 0; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 0)  begin i_start = 1'b1; i_op = 2'd2; i_a = 32'd100; i_b = 32'd7; end
            if (cyc == 10) i_flush = 1'b1;
            if (cyc == 11) begin i_flush = 1'b0; i_start = 1'b0; end
        end
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_idle_busy: got %b expected 0", o_busy);
        end
        // Flush in the accept cycle must cancel the accept
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_op = 2'd0; i_a = 32'd3; i_b = 32'd3;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_accept_busy: got %b expected 0", o_busy);
        end
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_accept_state: got busy %b expected 0", o_busy);
        end
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (o_done) dones++;
        end
        checks++;
        if (dones !== 0 || o_lo !== 32'h1 || o_hi !== 32'hFFFFFFFE || o_div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_done: got dones=%0d %h_%h dbz=%b expected 0 fffffffe_00000001 dbz=0",
                     dones, o_hi, o_lo, o_div_by_zero);
        end
    endtask

    task automatic test_reset_mid();
        run_op(2'd2, 32'd100, 32'd0);
        checks++;
        if ({r_dbz, r_hi} !== {1'b1, 32'h64}) begin
            errors++; $display("[TB] FAIL rstmid_setup: got dbz=%b hi=%h expected 1 00000064", r_dbz, r_hi);
        end
        for (int cyc = 0; cyc <= 21; cyc++) begin
            @(negedge clk);
            if (cyc == 0)  begin i_start = 1'b1; i_op = 2'd0; i_a = 32'd3; i_b = 32'd5; end
            if (cyc == 20) rst = 1'b1;
            if (cyc == 21) i_start = 1'b0;
        end
        #1;
        checks++;
        if ({o_hi, o_lo, o_done, o_div_by_zero, o_busy} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got hi=%h lo=%h done=%b dbz=%b busy=%b expected all zero",
                     o_hi, o_lo, o_done, o_div_by_zero, o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(2'd0, 32'd3, 32'd5);
        checks++;
        if (r_lat !== LAT || {r_hi, r_lo} !== 64'd15) begin
            errors++;
            $display("[TB] FAIL rstmid_recover: got lat=%0d %h_%h expected lat=%0d 00000000_0000000f",
                     r_lat, r_hi, r_lo, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int          pulses;
        int          first_cyc, second_cyc;
        logic [31:0] a0, b0, a1, b1;
        logic [63:0] got0, got1;
        logic [64:0] exp0, exp1;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp0 = ref_model(2'd0, a0, b0);
        exp1 = ref_model(2'd0, a1, b1);
        pulses = 0; first_cyc = -1; second_cyc = -1; got0 = '0; got1 = '0;
        for (int cyc = 0; cyc < 110; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin i_start = 1'b1; i_flush = 1'b0; i_op = 2'd0; i_a = a0; i_b = b0; end
            #1;
            if (o_done) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = cyc; got0 = {o_hi, o_lo}; i_a = a1; i_b = b1;
                end else if (pulses == 2) begin
                    second_cyc = cyc; got1 = {o_hi, o_lo}; i_start = 1'b0;
                end
            end
        end
        i_start = 1'b0;
        checks++;
        if (pulses !== 2 || first_cyc !== LAT || (second_cyc - first_cyc) !== WIDTH + 2) begin
            errors++;
            $display("[TB] FAIL b2b_timing: got pulses=%0d at %0d,%0d expected 2 at %0d,%0d",
                     pulses, first_cyc, second_cyc, LAT, LAT + WIDTH + 2);
        end
        checks++;
        if (got0 !== exp0[63:0] || got1 !== exp1[63:0]) begin
            errors++;
            $display("[TB] FAIL b2b_results: got %h, %h expected %h, %h", got0, got1, exp0[63:0], exp1[63:0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mulu_max();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
